// File: rtl/popcount_neuron_seq_pkg.sv
// Shared types and constants for the sequential popcount ternary neuron.
// Holds the FSM state encoding, the ternary activation codes and the popcount unit widths.
package popcount_neuron_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POS  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] ACT_POS  = 2'b01;
    localparam logic [1:0] ACT_NEG  = 2'b11;
    localparam logic [1:0] ACT_ZERO = 2'b00;

    localparam int PC_IN_W  = 25;
    localparam int PC_OUT_W = 5;

endpackage

// File: rtl/popcount_neuron_seq.sv
// Ternary neuron that time-multiplexes one external popcount25 unit over the
// positive and negative activation chunks, then thresholds the difference.
module popcount_neuron_seq
    import popcount_neuron_seq_pkg::*;
#(
    parameter int NCHUNK = 4,
    parameter int ACCW   = (NCHUNK > 4) ? $clog2(31 * NCHUNK + 1) : $clog2(25 * NCHUNK + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PC_IN_W*NCHUNK-1:0]     in_pos,
    input  logic [PC_IN_W*NCHUNK-1:0]     in_neg,
    input  logic [ACCW-1:0]               in_thr,
    output logic [PC_IN_W-1:0]            pc_a,
    input  logic [PC_OUT_W-1:0]           pc_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [1:0]                    out_act,
    output logic                          busy
);

    localparam int VW = PC_IN_W * NCHUNK;
    localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t             state_reg, state_next;
    logic [VW-1:0]      pos_reg, neg_reg;
    logic [ACCW-1:0]    thr_reg, acc_pos_reg, acc_neg_reg;
    logic [KW-1:0]      k_reg;
    logic               out_valid_reg;
    logic [1:0]         act_reg, act_next;
    logic               last_chunk;
    logic signed [ACCW:0] diff, thr_s;

    assign last_chunk = (k_reg == KW'(NCHUNK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)                   state_next = POS;
            POS:     if (last_chunk)                 state_next = NEG;
            NEG:     if (last_chunk)                 state_next = DONE;
            DONE:    if (out_valid_reg && out_ready) state_next = IDLE;
            default:                                 state_next = IDLE;
        endcase
    end

    // Signed compare at ACCW+1 bits so both diff and -thr are representable.
    always_comb begin
        diff  = $signed({1'b0, acc_pos_reg}) - $signed({1'b0, acc_neg_reg});
        thr_s = $signed({1'b0, thr_reg});
        if (diff > thr_s) begin
            act_next = ACT_POS;
        end else if (diff < -thr_s) begin
            act_next = ACT_NEG;
        end else begin
            act_next = ACT_ZERO;
        end
    end

    // DONE spends its first cycle registering the verdict, so out_act is never combinational.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_reg       <= '0;
            neg_reg       <= '0;
            thr_reg       <= '0;
            acc_pos_reg   <= '0;
            acc_neg_reg   <= '0;
            k_reg         <= '0;
            out_valid_reg <= 1'b0;
            act_reg       <= ACT_ZERO;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        pos_reg     <= in_pos;
                        neg_reg     <= in_neg;
                        thr_reg     <= in_thr;
                        acc_pos_reg <= '0;
                        acc_neg_reg <= '0;
                        k_reg       <= '0;
                    end
                end
                POS: begin
                    acc_pos_reg <= acc_pos_reg + ACCW'(pc_out);
                    k_reg       <= last_chunk ? '0 : k_reg + KW'(1);
                end
                NEG: begin
                    acc_neg_reg <= acc_neg_reg + ACCW'(pc_out);
                    k_reg       <= last_chunk ? '0 : k_reg + KW'(1);
                end
                DONE: begin
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                        act_reg       <= act_next;
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        act_reg       <= ACT_ZERO;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        pc_a = '0;
        case (state_reg)
            POS:     pc_a = pos_reg[k_reg*PC_IN_W +: PC_IN_W];
            NEG:     pc_a = neg_reg[k_reg*PC_IN_W +: PC_IN_W];
            default: pc_a = '0;
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = out_valid_reg;
    assign out_act   = act_reg;

endmodule

// File: tb/tb_popcount_neuron_seq.sv
// Directed bench for popcount_neuron_seq with an exact (or stuck-at-31) popcount25 model
// driving pc_out from pc_a.
module tb_popcount_neuron_seq;
    import popcount_neuron_seq_pkg::*;

    localparam int N    = 4;
    localparam int VW   = 25 * N;
    localparam int ACCW = 7;
    localparam int LAT  = 2 * N + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [VW-1:0]   in_pos = '0;
    logic [VW-1:0]   in_neg = '0;
    logic [ACCW-1:0] in_thr = '0;
    logic [24:0]     pc_a;
    logic [4:0]      pc_out;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [1:0]      out_act;
    logic            busy;
    logic            stuck = 1'b0;

    int checks = 0;
    int failures = 0;

    popcount_neuron_seq #(.NCHUNK(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pos(in_pos), .in_neg(in_neg), .in_thr(in_thr),
        .pc_a(pc_a), .pc_out(pc_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_act(out_act),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        pc_out = stuck ? 5'd31 : 5'($countones(pc_a));
    end

    typedef struct {
        logic [VW-1:0]   pos;
        logic [VW-1:0]   neg;
        logic [ACCW-1:0] thr;
        logic [1:0]      act;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [VW-1:0] ones(input int n);
        logic [VW-1:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Called #1 after the accept edge; follows the block until out_valid rises.
    task automatic wait_result(input logic [VW-1:0] pos, input logic [VW-1:0] neg,
                               input logic [1:0] exp_act, input string name);
        int i;
        int pca_bad;
        int busy_bad;
        logic [VW-1:0] v;
        logic [24:0] exp_pca;
        i = 0;
        pca_bad = 0;
        busy_bad = 0;
        while (i < 40) begin
            if (i < N) begin
                v = pos;
                exp_pca = v[i*25 +: 25];
            end else if (i < 2 * N) begin
                v = neg;
                exp_pca = v[(i-N)*25 +: 25];
            end else begin
                exp_pca = '0;
            end
            if (pc_a !== exp_pca) pca_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (out_valid === 1'b1) break;
            @(posedge clk);
            #1;
            i++;
        end
        check({name, " latency"}, 32'(i), 32'(LAT));
        check({name, " pc_a seq errs"}, 32'(pca_bad), 32'd0);
        check({name, " busy errs"}, 32'(busy_bad), 32'd0);
        check({name, " out_act"}, 32'(out_act), 32'(exp_act));
        check({name, " in_ready in DONE"}, 32'(in_ready), 32'd0);
        $display("txn %s: latency=%0d out_act=%b expected=%b", name, i, out_act, exp_act);
    endtask

    task automatic handshake(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " out_valid after ack"}, 32'(out_valid), 32'd0);
        check({name, " in_ready after ack"}, 32'(in_ready), 32'd1);
    endtask

    task automatic accept(input logic [VW-1:0] pos, input logic [VW-1:0] neg,
                          input logic [ACCW-1:0] thr, input string name);
        int guard;
        guard = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({name, " in_ready before accept"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_pos = pos;
        in_neg = neg;
        in_thr = thr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input logic [VW-1:0] pos, input logic [VW-1:0] neg,
                           input logic [ACCW-1:0] thr, input logic [1:0] exp_act, input string name);
        accept(pos, neg, thr, name);
        wait_result(pos, neg, exp_act, name);
        handshake(name);
    endtask

    initial begin
        logic [1:0] held_act;
        int bad;

        vecs[0] = '{ones(100), '0, 7'd10, ACT_POS};
        vecs[1] = '{'0, ones(100), 7'd10, ACT_NEG};
        vecs[2] = '{ones(30), ones(20) << 50, 7'd10, ACT_ZERO};
        vecs[3] = '{ones(30), ones(20) << 50, 7'd9, ACT_POS};
        vecs[4] = '{'0, '0, 7'd0, ACT_ZERO};
        vecs[5] = '{ones(5) << 95, ones(40) << 10, 7'd35, ACT_ZERO};
        vecs[6] = '{ones(5) << 95, ones(40) << 10, 7'd34, ACT_NEG};
        vecs[7] = '{ones(100), ones(100), 7'd0, ACT_ZERO};
        vecs[8] = '{ones(100), '0, 7'd127, ACT_ZERO};
        vecs[9] = '{ones(13) << 7, ones(12) << 60, 7'd0, ACT_POS};

        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_act", 32'(out_act), 32'(ACT_ZERO));
        check("reset busy", 32'(busy), 32'd0);
        check("reset pc_a", 32'(pc_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-reset in_ready", 32'(in_ready), 32'd1);

        for (int v = 0; v < 10; v++) begin
            run_vec(vecs[v].pos, vecs[v].neg, vecs[v].thr, vecs[v].act, $sformatf("vec%0d", v));
        end

        // Backpressure with a second request already waiting on in_valid.
        accept(ones(60), ones(10), 7'd20, "bp_a");
        wait_result(ones(60), ones(10), ACT_POS, "bp_a");
        held_act = out_act;
        in_valid = 1'b1;
        in_pos = ones(10);
        in_neg = ones(60);
        in_thr = 7'd20;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || out_act !== held_act || in_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        check("bp hold errs", 32'(bad), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp out_valid after ack", 32'(out_valid), 32'd0);
        check("bp in_ready after ack", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_b accepted", 32'(busy), 32'd1);
        wait_result(ones(10), ones(60), ACT_NEG, "bp_b");
        handshake("bp_b");

        // Reset pulse during NEG chunk 2.
        accept(ones(100), ones(100), 7'd0, "rst_mid");
        repeat (N + 2) @(posedge clk);
        #1;
        check("rst_mid pc_a neg chunk2", 32'(pc_a), 32'h1ffffff);
        rst_n = 1'b0;
        #1;
        check("rst_mid out_valid", 32'(out_valid), 32'd0);
        check("rst_mid out_act", 32'(out_act), 32'(ACT_ZERO));
        check("rst_mid busy", 32'(busy), 32'd0);
        check("rst_mid pc_a", 32'(pc_a), 32'd0);
        check("rst_mid in_ready", 32'(in_ready), 32'd1);
        check("rst_mid acc_neg", 32'(dut.acc_neg_reg), 32'd0);
        #1;
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("rst_mid no late result", 32'(bad), 32'd0);
        $display("txn rst_mid: reset applied in NEG chunk 2");
        run_vec('0, ones(10), 7'd10, ACT_ZERO, "after_rst");

        // Stuck popcount: every chunk reports 31.
        stuck = 1'b1;
        accept(ones(100), '0, 7'd0, "stuck");
        wait_result(ones(100), '0, ACT_ZERO, "stuck");
        check("stuck acc_pos", 32'(dut.acc_pos_reg), 32'd124);
        check("stuck acc_neg", 32'(dut.acc_neg_reg), 32'd124);
        handshake("stuck");
        stuck = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
